// File: rtl/input_datapath_if.sv
// Receive-side bus bundle: host word stream in, packed frame out, plus status.
//   slave  : view used by input_datapath (consumes host words, produces frames)
//   master : view used by whoever drives the host side and sinks the frames
//   src_valid/src_ready/data_in : host word handshake
//   flush                       : discard partial frame
//   sys_valid/sys_ready/systolic_input : frame handshake toward the array
//   beat_count, rx_done          : status for the top-level controller
interface input_datapath_if #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 512
);
    localparam int unsigned BEATS = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);

    logic                 src_valid;
    logic                 src_ready;
    logic [IN_WIDTH-1:0]  data_in;
    logic                 flush;
    logic                 sys_ready;
    logic                 sys_valid;
    logic [OUT_WIDTH-1:0] systolic_input;
    logic [CNT_W-1:0]     beat_count;
    logic                 rx_done;

    modport slave (
        input  src_valid,
        input  data_in,
        input  flush,
        input  sys_ready,
        output src_ready,
        output sys_valid,
        output systolic_input,
        output beat_count,
        output rx_done
    );

    modport master (
        output src_valid,
        output data_in,
        output flush,
        output sys_ready,
        input  src_ready,
        input  sys_valid,
        input  systolic_input,
        input  beat_count,
        input  rx_done
    );
endinterface

// File: rtl/input_datapath.sv
// Packs BEATS consecutive IN_WIDTH-bit host words into one OUT_WIDTH-bit frame
// and hands it to the systolic array load port.
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : input_datapath_if.slave
//     src_valid/src_ready/data_in : host word handshake (word 0 lands in lane 0)
//     flush                       : drop partial frame (ignored while a frame is full)
//     sys_valid/sys_ready         : frame handshake, systolic_input held until taken
//     beat_count                  : words captured in the current partial frame
//     rx_done                     : one-cycle pulse the cycle after a frame handoff
module input_datapath #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input_datapath_if.slave       bus
);
    localparam int unsigned BEATS = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     beat_count_q, beat_count_d;
    logic [OUT_WIDTH-1:0] frame_q, frame_d;
    logic                 rx_done_q, rx_done_d;

    logic                 src_ready_c;
    logic                 accept_c;
    logic                 last_beat_c;

    // Ready depends only on registered state plus reset/flush; never on sys_ready.
    assign src_ready_c = (state_q == FILL) && !reset && !bus.flush;
    assign accept_c    = bus.src_valid && src_ready_c;
    assign last_beat_c = (beat_count_q == CNT_W'(BEATS - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        beat_count_d = beat_count_q;
        frame_d      = frame_q;
        rx_done_d    = 1'b0;

        unique case (state_q)
            FILL: begin
                if (bus.flush) begin
                    beat_count_d = '0;
                end else if (accept_c) begin
                    // Only the addressed lane changes; others keep prior contents.
                    for (int unsigned i = 0; i < BEATS; i++) begin
                        if (beat_count_q == CNT_W'(i)) begin
                            frame_d[i*IN_WIDTH +: IN_WIDTH] = bus.data_in;
                        end
                    end
                    if (last_beat_c) begin
                        beat_count_d = '0;
                        state_d      = FULL;
                    end else begin
                        beat_count_d = beat_count_q + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                // Frame held until the array takes it; flush cannot discard it.
                if (bus.sys_ready) begin
                    state_d   = FILL;
                    rx_done_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            beat_count_q <= '0;
            frame_q      <= '0;
            rx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
            frame_q      <= frame_d;
            rx_done_q    <= rx_done_d;
        end
    end

    assign bus.src_ready      = src_ready_c;
    assign bus.sys_valid      = (state_q == FULL);
    assign bus.systolic_input = frame_q;
    assign bus.beat_count     = beat_count_q;
    assign bus.rx_done        = rx_done_q;

endmodule

// File: tb/tb_input_datapath.sv
// Directed bench for input_datapath with a frame scoreboard.
module tb_input_datapath;
    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 512;

    logic clk;
    logic reset;

    input_datapath_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

    input_datapath #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (what the block should hold after each edge).
    logic             m_fill = 1'b1;
    int               m_beat = 0;
    logic [OUT_W-1:0] m_frame = '0;
    logic             m_rx = 1'b0;
    logic             last_acc;
    logic [OUT_W-1:0] exp_q[$];

    int cyc_n       = 0;
    int last_rx_cyc = -1;
    int prev_rx_cyc = -1;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check outputs at negedge, advance model, return after edge.
    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic fl,
                       input logic sr, input logic rst);
        logic acc;
        bus.src_valid = v;
        bus.data_in   = d;
        bus.flush     = fl;
        bus.sys_ready = sr;
        reset         = rst;
        @(negedge clk);
        chk("src_ready",  {511'd0, bus.src_ready}, {511'd0, m_fill && !rst && !fl});
        chk("sys_valid",  {511'd0, bus.sys_valid}, {511'd0, !m_fill});
        chk("beat_count", {509'd0, bus.beat_count}, {509'd0, 3'(m_beat)});
        chk("rx_done",    {511'd0, bus.rx_done}, {511'd0, m_rx});
        if (m_fill) begin
            chk("frame_fill", bus.systolic_input, m_frame);
        end else if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard_empty: observed sys_valid with no expected frame");
        end else begin
            chk("frame_full", bus.systolic_input, exp_q[0]);
        end
        if (bus.rx_done) begin
            prev_rx_cyc = last_rx_cyc;
            last_rx_cyc = cyc_n;
        end

        acc  = v && m_fill && !rst && !fl;
        m_rx = 1'b0;
        if (rst) begin
            m_fill  = 1'b1;
            m_beat  = 0;
            m_frame = '0;
            exp_q.delete();
        end else if (m_fill) begin
            if (fl) begin
                m_beat = 0;
            end else if (acc) begin
                m_frame[m_beat*IN_W +: IN_W] = d;
                if (m_beat == 7) begin
                    m_beat = 0;
                    m_fill = 1'b0;
                    exp_q.push_back(m_frame);
                end else begin
                    m_beat++;
                end
            end
        end else if (sr) begin
            m_fill = 1'b1;
            m_rx   = 1'b1;
            void'(exp_q.pop_front());
        end
        last_acc = acc;

        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Present n words (base+i) continuously until all are accepted.
    task automatic send_words(input int n, input logic [IN_W-1:0] base, input logic sr);
        int idx   = 0;
        int guard = 0;
        while (idx < n && guard < 4*n + 20) begin
            cyc(1'b1, base + IN_W'(idx), 1'b0, sr, 1'b0);
            if (last_acc) idx++;
            guard++;
        end
        if (idx < n) begin
            n_total++;
            $error("FAIL send_timeout: accepted %0d words, required %0d", idx, n);
        end
    endtask

    logic [IN_W-1:0] w;

    initial begin
        bus.src_valid = 1'b0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.sys_ready = 1'b0;
        reset         = 1'b1;

        // 1: reset for two cycles, then release.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        chk("reset_frame", bus.systolic_input, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // 2: two back-to-back frames with sys_ready high.
        for (int k = 1; k <= 8; k++) begin
            w = 64'h1111_1111_1111_1111 * 64'(k);
            cyc(1'b1, w, 1'b0, 1'b1, 1'b0);
        end
        chk("t2_valid", {511'd0, bus.sys_valid}, {511'd1});
        chk("t2_lane0", {448'd0, bus.systolic_input[63:0]}, {448'd0, 64'h1111_1111_1111_1111});
        chk("t2_lane7", {448'd0, bus.systolic_input[511:448]}, {448'd0, 64'h8888_8888_8888_8888});
        send_words(8, 64'hA000_0000_0000_0000, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t2_period", 512'(last_rx_cyc - prev_rx_cyc), 512'd9);

        // 3: back-pressure on the frame side.
        send_words(8, 64'hB000_0000_0000_0000, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0, 1'b0);
        chk("t3_lane3", {448'd0, bus.systolic_input[255:192]}, {448'd0, 64'hB000_0000_0000_0003});
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_rx", {511'd0, bus.rx_done}, {511'd1});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // 4: src_valid toggled every cycle.
        w = 64'hC000_0000_0000_0000;
        for (int i = 0; i < 16; i++) begin
            cyc((i % 2) == 0, w, 1'b0, 1'b0, 1'b0);
            if (last_acc) w = w + 64'd1;
        end
        chk("t4_beat", {509'd0, bus.beat_count}, 512'd0);
        chk("t4_valid", {511'd0, bus.sys_valid}, {511'd1});
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 5: flush mid-frame, then flush while full.
        send_words(3, 64'hD000_0000_0000_0000, 1'b0);
        cyc(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 1'b0, 1'b0);
        chk("t5_beat", {509'd0, bus.beat_count}, 512'd0);
        send_words(8, 64'hE000_0000_0000_0000, 1'b0);
        chk("t5_lane0", {448'd0, bus.systolic_input[63:0]}, {448'd0, 64'hE000_0000_0000_0000});
        cyc(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_keep", {511'd0, bus.sys_valid}, {511'd1});
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 6: reset in the middle of a frame.
        send_words(5, 64'hF000_0000_0000_0000, 1'b0);
        cyc(1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b1);
        chk("t6_beat", {509'd0, bus.beat_count}, 512'd0);
        chk("t6_valid", {511'd0, bus.sys_valid}, 512'd0);
        chk("t6_frame", bus.systolic_input, '0);
        send_words(8, 64'h7000_0000_0000_0000, 1'b0);
        chk("t6_lane0", {448'd0, bus.systolic_input[63:0]}, {448'd0, 64'h7000_0000_0000_0000});
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
